// File: rtl/load_store_unit.sv
// load_store_unit: RISC-V byte/half/word load-store lane steering to a sync-read dmem; optional misalign trap via LSU_MISALIGN_TRAP_EN
module load_store_unit #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  dmem_en,
  output logic [3:0]            dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_din,
  input  logic [31:0]           dmem_dout,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  misalign,
  output logic [7:0]            misalign_count
);
  logic [1:0]  off;
  logic        f3_ok;
  logic        mis;
  logic        go;
  logic [3:0]  mask;
  logic        ld_q, ld_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] fmt;
  logic        unused;
  assign off       = req_addr[1:0];
  assign dmem_addr = req_addr[ADDR_WIDTH+1:2];
  assign unused    = ^req_addr[31:ADDR_WIDTH+2];
  // Request decode: legal funct3, misalignment, and whether dmem is touched
  always_comb begin
    f3_ok = req_we ? (!req_funct3[2] && req_funct3[1:0] != 2'b11)
                   : (req_funct3[1:0] != 2'b11 && !(req_funct3[2] && req_funct3[1]));
    mis   = (req_funct3[1:0] == 2'b01 && off[0]) || (req_funct3[1:0] == 2'b10 && off != 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
    go    = req_valid && !rst && f3_ok && !mis;
`else
    go    = req_valid && !rst && f3_ok;
`endif
    mask  = req_funct3[1:0] == 2'b00 ? 4'b0001 << off :
            req_funct3[1:0] == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  end
  // Memory port: store data is replicated so every lane the mask selects holds the right bytes
  always_comb begin
    dmem_en  = go;
    dmem_we  = (go && req_we) ? mask : 4'b0000;
    dmem_din = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
               req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
  end
  // Load return path: lane select and extension of the synchronous read word
  always_comb begin
    lane_b    = dmem_dout[8*off_q +: 8];
    lane_h    = off_q[1] ? dmem_dout[31:16] : dmem_dout[15:0];
    fmt       = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & lane_b[7]}}, lane_b} :
                f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & lane_h[15]}}, lane_h} : dmem_dout;
    rsp_valid = ld_q && !rst;
    ld_d      = go && !req_we;
    f3_d      = ld_d ? req_funct3 : f3_q;
    off_d     = ld_d ? off : off_q;
    data_d    = rsp_valid ? fmt : data_q;
    rsp_data  = data_d;
  end
  // Pending-load bookkeeping and held response data
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_q   <= 1'b0;
      f3_q   <= 3'b000;
      off_q  <= 2'b00;
      data_q <= 32'h0;
    end else begin
      ld_q   <= ld_d;
      f3_q   <= f3_d;
      off_q  <= off_d;
      data_q <= data_d;
    end
  end
`ifdef LSU_MISALIGN_TRAP_EN
  logic       mis_q, mis_d;
  logic [7:0] cnt_q, cnt_d;
  // Misalign pulse and saturating counter
  always_comb begin
    mis_d = req_valid && !rst && f3_ok && mis;
    cnt_d = (mis_d && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  end
  // Misalign state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
      cnt_q <= 8'h00;
    end else begin
      mis_q <= mis_d;
      cnt_q <= cnt_d;
    end
  end
  assign misalign       = mis_q;
  assign misalign_count = cnt_q;
`else
  assign misalign       = 1'b0;
  assign misalign_count = 8'h00;
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit against a byte-level memory model
module tb_load_store_unit;
  localparam int AW = 14;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b0;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic          dmem_en;
  logic [3:0]    dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_din;
  logic [31:0]   dmem_dout = 32'h0;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic          misalign;
  logic [7:0]    misalign_count;

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_din(dmem_din),
    .dmem_dout(dmem_dout), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .misalign(misalign), .misalign_count(misalign_count)
  );

  always #5 clk = ~clk;

  // data memory environment: synchronous read, write-first
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    logic [31:0] w;
    if (dmem_en) begin
      w = mem[dmem_addr];
      for (int i = 0; i < 4; i++) if (dmem_we[i]) w[8*i +: 8] = dmem_din[8*i +: 8];
      mem[dmem_addr] <= w;
      dmem_dout <= w;
    end
  end

  int checks = 0;
  int errors = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // model state
  logic [7:0]  gm [0:(1<<(AW+2))-1];
  bit          go = 1'b0;
  bit          pv = 1'b0;
  logic [31:0] pd = 32'h0;
  logic [31:0] hold = 32'h0;
  bit          mp = 1'b0;
  int          cnt = 0;
  // hand-computed expectations set by the driver for the current cycle
  bit          lit_rsp = 1'b0, lit_rv = 1'b0, lit_we = 1'b0, lit_din_en = 1'b0;
  bit          lit_addr_en = 1'b0, lit_mis = 1'b0, lit_cnt = 1'b0;
  logic [31:0] lit_rd = 32'h0, lit_din = 32'h0;
  logic [3:0]  lit_wev = 4'h0;
  logic [AW-1:0] lit_addr = '0;
  int          lit_cntv = 0;

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
    for (int i = 0; i < (1<<(AW+2)); i++) gm[i] = 8'h0;
  end

  // compare process: inputs are stable here, outputs reflect the previous edge
  always @(negedge clk) begin
    int sz;
    bit uns, ld, ok, mis, acc;
    logic [AW+1:0] ea, base;
    logic [3:0] ew;
    logic [31:0] v, ed;
    if (go) begin
      if (rst) begin
        chk("en_in_reset", dmem_en, 0);
        chk("we_in_reset", dmem_we, 0);
        chk("rsp_valid_in_reset", rsp_valid, 0);
        pv = 0; hold = 0; mp = 0; cnt = 0;
      end else begin
        chk("rsp_valid", rsp_valid, pv);
        if (pv) hold = pd;
        chk("rsp_data", rsp_data, hold);
        chk("misalign", misalign, mp);
        chk("misalign_count", misalign_count, cnt);
        if (lit_rsp) begin
          chk("lit_rsp_valid", rsp_valid, lit_rv);
          chk("lit_rsp_data", rsp_data, lit_rd);
          chk("lit_model_data", hold, lit_rd);
        end
        if (lit_mis) chk("lit_misalign", misalign, 1);
        if (lit_cnt) chk("lit_misalign_count", misalign_count, lit_cntv);
        if (lit_we) chk("lit_dmem_we", dmem_we, lit_wev);
        if (lit_din_en) chk("lit_dmem_din", dmem_din, lit_din);
        if (lit_addr_en) chk("lit_dmem_addr", dmem_addr, lit_addr);
        ld  = !req_we;
        sz  = req_funct3[1:0] == 2'd0 ? 1 : req_funct3[1:0] == 2'd1 ? 2 : req_funct3[1:0] == 2'd2 ? 4 : 0;
        uns = req_funct3[2];
        ok  = req_valid && sz != 0 && (ld ? !(uns && sz == 4) : !uns);
        ea  = req_addr[AW+1:0];
        mis = ok && (ea % sz) != 0;
        acc = ok && !(TRAP && mis);
        base = ok ? ea - (ea % sz) : ea;
        ew = 4'h0;
        if (acc && !ld) for (int i = 0; i < sz; i++) ew[(base + i) % 4] = 1'b1;
        chk("dmem_en", dmem_en, acc);
        chk("dmem_we", dmem_we, ew);
        if (acc) chk("dmem_addr", dmem_addr, ea / 4);
        if (acc && !ld) begin
          ed = sz == 1 ? {4{req_wdata[7:0]}} : sz == 2 ? {2{req_wdata[15:0]}} : req_wdata;
          chk("dmem_din", dmem_din, ed);
        end
        pv = acc && ld;
        if (pv) begin
          v = 32'h0;
          for (int i = 0; i < sz; i++) v[8*i +: 8] = gm[base + i];
          pd = (sz < 4 && !uns && v[8*sz-1]) ? v | (32'hFFFF_FFFF << (8*sz)) : v;
        end
        if (acc && !ld) for (int i = 0; i < sz; i++) gm[base + i] = req_wdata[8*i +: 8];
        mp = TRAP && mis;
        if (mp && cnt < 255) cnt++;
      end
    end
  end

  task automatic issue(bit v, bit we, logic [2:0] f, logic [31:0] a, logic [31:0] d);
    @(posedge clk);
    #1;
    req_valid = v; req_we = we; req_funct3 = f; req_addr = a; req_wdata = d;
    lit_rsp = 0; lit_we = 0; lit_din_en = 0; lit_addr_en = 0; lit_mis = 0; lit_cnt = 0;
  endtask

  initial begin
    logic [31:0] a;
    bit r;
    repeat (2) @(posedge clk);
    #1 go = 1;
    issue(1, 1, 3'b010, 32'h10, 32'd100); rst = 0;
    issue(1, 0, 3'b010, 32'h10, 32'h0);
    issue(0, 0, 3'b000, 32'h0, 32'h0); lit_rsp = 1; lit_rv = 1; lit_rd = 32'h0000_0064;
    issue(1, 1, 3'b000, 32'h13, 32'h80);
    lit_we = 1; lit_wev = 4'b1000; lit_din_en = 1; lit_din = 32'h8080_8080;
    issue(1, 0, 3'b000, 32'h13, 32'h0);
    issue(1, 0, 3'b100, 32'h13, 32'h0); lit_rsp = 1; lit_rv = 1; lit_rd = 32'hFFFF_FF80;
    issue(0, 0, 3'b000, 32'h0, 32'h0);  lit_rsp = 1; lit_rv = 1; lit_rd = 32'h0000_0080;
    issue(1, 1, 3'b001, 32'h22, 32'h8080); lit_we = 1; lit_wev = 4'b1100;
    issue(1, 0, 3'b101, 32'h22, 32'h0);
    issue(1, 0, 3'b001, 32'h22, 32'h0); lit_rsp = 1; lit_rv = 1; lit_rd = 32'h0000_8080;
    issue(0, 0, 3'b000, 32'h0, 32'h0);  lit_rsp = 1; lit_rv = 1; lit_rd = 32'hFFFF_8080;
    issue(1, 0, 3'b010, 32'h10, 32'h0);
    issue(1, 0, 3'b010, 32'h20, 32'h0); lit_rsp = 1; lit_rv = 1; lit_rd = 32'h8000_0064;
    issue(1, 0, 3'b000, 32'h13, 32'h0); lit_rsp = 1; lit_rv = 1; lit_rd = 32'h8080_0000;
    issue(0, 0, 3'b000, 32'h0, 32'h0);  lit_rsp = 1; lit_rv = 1; lit_rd = 32'hFFFF_FF80;
    issue(1, 0, 3'b010, 32'h10, 32'h0);
    issue(0, 0, 3'b000, 32'h0, 32'h0); rst = 1;
    issue(0, 0, 3'b000, 32'h0, 32'h0); rst = 0; lit_rsp = 1; lit_rv = 0; lit_rd = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1, 1, 3'b010, 32'h11, 32'hDEAD_BEEF); lit_we = 1; lit_wev = 4'b0000;
    issue(0, 0, 3'b000, 32'h0, 32'h0); lit_mis = 1;
    repeat (299) issue(1, 1, 3'b010, 32'h11, 32'h0);
    issue(0, 0, 3'b000, 32'h0, 32'h0); lit_cnt = 1; lit_cntv = 255;
`else
    issue(1, 1, 3'b010, 32'h11, 32'h1234_5678);
    lit_we = 1; lit_wev = 4'b1111; lit_addr_en = 1; lit_addr = 4;
`endif
    repeat (4000) begin
      a = $urandom;
      a[15:8] = 8'h0;
      r = $urandom_range(0, 99) < 2;
      issue($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 40, 3'($urandom_range(0, 7)), a, $urandom);
      rst = r;
    end
    issue(0, 0, 3'b000, 32'h0, 32'h0); rst = 0;
    issue(0, 0, 3'b000, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, the dmem word-address width.
REQ-002 SHALL have port clk, input, 1 bit, the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-004 SHALL have ports req_valid (input, 1) and req_we (input, 1): a request is present this cycle, and it is a store (1) or a load (0).
REQ-005 SHALL have port req_funct3, input, 3 bits, the RISC-V load/store funct3.
REQ-006 SHALL have ports req_addr (input, 32), the byte address, and req_wdata (input, 32), the unaligned store source (rs2).
REQ-007 SHALL have ports dmem_en (output, 1), dmem_we (output, 4, byte write mask), dmem_addr (output, ADDR_WIDTH) and dmem_din (output, 32).
REQ-008 SHALL have port dmem_dout, input, 32 bits, the synchronous-read data, valid one cycle after dmem_en.
REQ-009 SHALL have ports rsp_valid (output, 1) and rsp_data (output, 32): the load result and its qualifier.
REQ-010 SHALL have port misalign, output, 1 bit, a misaligned-access pulse.
REQ-011 SHALL have port misalign_count, output, 8 bits, the saturating misaligned-access count.

Function
REQ-012 SHALL accept one request per cycle, with no back-pressure.
REQ-013 dmem_en, dmem_we, dmem_addr and dmem_din SHALL be combinational from the request; dmem_addr = req_addr[ADDR_WIDTH+1:2]; off = req_addr[1:0].
REQ-014 Valid funct3 values: loads 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000 sb, 001 sh, 010 sw.
REQ-015 Invalid funct3: dmem_en=0, dmem_we=0, no response, no misalign.
REQ-016 sb: dmem_we=4'b0001<<off; dmem_din = the byte replicated x4.
REQ-017 sh: dmem_we=off[1]?4'b1100:4'b0011; dmem_din = the halfword replicated x2.
REQ-018 sw: dmem_we=4'b1111; dmem_din=req_wdata.
REQ-019 Load: dmem_en=1, dmem_we=0.
REQ-020 On a load, funct3 and off SHALL be registered.
REQ-021 In the next cycle, rsp_valid=1 for exactly one cycle and rsp_data = dmem_dout after lane selection and sign or zero extension.
REQ-022 rsp_data SHALL be a registered output: a response issued in cycle N+1 for a load accepted in cycle N is held until the next response.
REQ-023 Back-to-back loads SHALL produce back-to-back responses, in order.
REQ-024 Stores SHALL produce no response.
REQ-025 A store followed by a load to the same word in the next cycle SHALL return the stored data; memory write-first ordering is relied on, with no forwarding inside the block.

Reset
REQ-026 While rst=1: dmem_en=0, dmem_we=0, and any request is ignored.
REQ-027 After a cycle with rst=1: rsp_valid=0, rsp_data=0, misalign=0, misalign_count=0.
REQ-028 A load accepted in the cycle before rst is asserted SHALL produce no response.
REQ-029 Operation SHALL resume on the first cycle with rst=0.

Configuration
REQ-030 The macro is LSU_MISALIGN_TRAP_EN.
REQ-031 With LSU_MISALIGN_TRAP_EN defined, a misaligned access (halfword with off[0]=1, or word with off!=0) SHALL be suppressed: dmem_en=0, dmem_we=0, no response.
REQ-032 With LSU_MISALIGN_TRAP_EN defined, a misaligned access SHALL pulse misalign for one cycle, one cycle after acceptance, and increment misalign_count, saturating at 255.
REQ-033 Without LSU_MISALIGN_TRAP_EN, halfword accesses SHALL ignore off[0] and word accesses SHALL ignore off; the access proceeds normally.
REQ-034 Without LSU_MISALIGN_TRAP_EN, misalign and misalign_count SHALL be tied to 0.

Verification
REQ-035 Store and load a word: sw 100 @0x10, then lw @0x10 -> rsp_valid one cycle later, rsp_data=0x00000064.
REQ-036 Byte sign/zero extension: sb 0x80 @0x13 -> dmem_we=4'b1000, dmem_din=0x80808080; then lb @0x13 -> 0xFFFFFF80, and lbu @0x13 -> 0x00000080.
REQ-037 Halfword: sh 0x8080 @0x22 -> dmem_we=4'b1100; then lhu @0x22 -> 0x00008080, and lh @0x22 -> 0xFFFF8080.
REQ-038 Pipelining and reset: 3 back-to-back loads -> 3 consecutive rsp_valid cycles in order; a load accepted, then rst=1 next cycle -> rsp_valid stays 0 and rsp_data=0.
REQ-039 Misalign with LSU_MISALIGN_TRAP_EN defined: sw @0x11 -> dmem_we=0 and misalign pulses once; after 300 such stores, misalign_count=255.
REQ-040 Misalign without LSU_MISALIGN_TRAP_EN: sw @0x11 -> dmem_we=4'b1111 with dmem_addr at word 4.
